mips_decode_alu: RTL and testbench
==================================

Name: mips_decode_alu

Overview:
- Single-cycle MIPS decode-and-execute slice: main control decoder, ALU-control decoder and 32-bit ALU in one registered stage.
- Sits between instruction fetch/register file and data memory/PC update logic.
- Consumes opcode/funct/shamt plus operand data.
- Produces datapath control strobes, ALU result and zero flag one clock later.

Parameters:
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  inputs valid this cycle
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- shamt  in  5  instr[10:6]
- imm16  in  16  instr[15:0]
- rs_data  in  32  ALU operand A
- rt_data  in  32  register operand B
- out_valid  out  1  registered in_valid
- reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write  out  1 each  datapath controls
- branch, branch_not, jump, jump_r, jal  out  1 each  PC controls
- alu_op  out  4  main-decoder ALU class
- alu_ctl  out  4  ALU function select
- alu_result  out  32  ALU output
- zero  out  1  alu_result==0
- illegal  out  1  unsupported opcode/funct
- ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Clocking and reset:
  - All outputs are registered on posedge clk; latency is exactly 1 cycle.
  - The stage captures every cycle regardless of in_valid; out_valid only qualifies the outputs.
  - rst asserted, at any time including mid-stream: every output is 0 immediately, except zero=1 (result 0). Outputs stay so until the first clock edge after rst deasserts.
- Immediate extension:
  - Zero-extend for andi, ori, xori.
  - Sign-extend otherwise.
- Operand B: alu_src ? extended imm : rt_data.
- alu_op codes: 0 ADD, 1 SUB, 2 RTYPE, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 LUI.
- alu_ctl codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 SUB, 9 SLT, 10 SLTU, 11 LUI.
- alu_ctl mapping:
  - alu_op≠2 maps directly.
  - alu_op=2 decodes funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x08 (jr) ADD.
- ALU operations:
  - Shifts operate on B by shamt; A is ignored.
  - SLT is signed; SLTU is unsigned; both give result 0 or 1.
  - LUI gives {imm16,16'b0}.
  - ADD/SUB wrap modulo 2^32.
- Opcode decode (all unlisted signals 0):
  - 0x00 R-type: reg_dst, reg_write, alu_op=2.
  - 0x00 with funct 0x08 (jr): jump_r=1, reg_write=0.
  - 0x23 lw: alu_src, mem_read, mem_to_reg, reg_write, ADD.
  - 0x2B sw: alu_src, mem_write, ADD.
  - 0x04 beq: branch, SUB.
  - 0x05 bne: branch_not, SUB.
  - 0x08 addi, 0x09 addiu: alu_src, reg_write, ADD.
  - 0x0C andi, 0x0D ori, 0x0E xori: alu_src, reg_write, AND/OR/XOR respectively.
  - 0x0A slti, 0x0B sltiu: alu_src, reg_write, SLT/SLTU respectively.
  - 0x0F lui: alu_src, reg_write, LUI.
  - 0x02 j: jump.
  - 0x03 jal: jal, reg_write (link target is r31, selected externally).
- Illegal handling:
  - Unknown opcode, or R-type with unlisted funct: illegal=1, all strobes 0, alu_ctl=ADD.
  - Result still computed, never written.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: ovf registered high when add/addi/sub (funct 0x20/0x22, opcode 0x08) produce signed overflow. Result still wraps; no trap.
- Undefined: ovf is tied 0. The unsigned variants never flag in either case.

Test Plan:
- rst pulse mid-stream: outputs 0 and zero=1 within the same cycle, before any clock edge; first post-reset edge captures new inputs.
- R add, rs=5, rt=7: next cycle alu_result=12, reg_dst=1, reg_write=1, alu_ctl=2.
- beq with rs=rt=0x1234: zero=1, branch=1, alu_ctl=8. Same with bne and rs≠rt: zero=0, branch_not=1.
- ori rs=0xFFFF0000, imm16=0x8001: result 0xFFFF8001 (zero-extend). addi with the same imm: result 0xFFFF0000+0xFFFF8001 mod 2^32 = 0xFFFE8001.
- sra rt=0x80000000, shamt=4: 0xF8000000. slt -1<1: 1. sltu 0xFFFFFFFF<1: 0. lui imm 0xABCD: 0xABCD0000.
- jr: jump_r=1, reg_write=0. jal: jal=1, reg_write=1. Opcode 0x3F: illegal=1, no strobes. ALU_OVF_EN with add 0x7FFFFFFF+1: ovf=1, result 0x80000000.

Source files
------------

// File: rtl/mips_decode_alu_if.sv
// mips_decode_alu_if: instruction/operand inputs and registered control/result outputs of mips_decode_alu
interface mips_decode_alu_if #(parameter int DW = 32);
  logic in_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [15:0] imm16;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic out_valid;
  logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
  logic branch, branch_not, jump, jump_r, jal;
  logic [3:0] alu_op;
  logic [3:0] alu_ctl;
  logic [DW-1:0] alu_result;
  logic zero;
  logic illegal;
  logic ovf;
  modport master (
    output in_valid, opcode, funct, shamt, imm16, rs_data, rt_data,
    input out_valid, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
    input branch, branch_not, jump, jump_r, jal, alu_op, alu_ctl, alu_result, zero, illegal, ovf
  );
  modport slave (
    input in_valid, opcode, funct, shamt, imm16, rs_data, rt_data,
    output out_valid, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write,
    output branch, branch_not, jump, jump_r, jal, alu_op, alu_ctl, alu_result, zero, illegal, ovf
  );
endinterface

// File: rtl/mips_decode_alu.sv
// mips_decode_alu: registered MIPS main/ALU-control decode and 32-bit ALU, one cycle latency.
// Define ALU_OVF_EN to flag signed overflow on add/addi/sub; otherwise ovf stays 0.
module mips_decode_alu #(parameter int DW = 32) (
  input logic clk,
  input logic rst,
  mips_decode_alu_if.slave bus
);
  logic regDst, aluSrc, memRead, memWrite, memToReg, regWrite;
  logic branch, branchNot, jump, jumpR, jal, illegal, funOk, ovfNext;
  logic [3:0] aluOp, aluCtl, funCtl;
  logic [DW-1:0] immExt, opA, opB, res;
  assign opA = bus.rs_data;
  always_comb begin
    funCtl = 4'd2;
    funOk = 1'b1;
    case (bus.funct)
      6'h20, 6'h21, 6'h08: funCtl = 4'd2;
      6'h22, 6'h23: funCtl = 4'd8;
      6'h24: funCtl = 4'd0;
      6'h25: funCtl = 4'd1;
      6'h26: funCtl = 4'd3;
      6'h27: funCtl = 4'd4;
      6'h2A: funCtl = 4'd9;
      6'h2B: funCtl = 4'd10;
      6'h00: funCtl = 4'd5;
      6'h02: funCtl = 4'd6;
      6'h03: funCtl = 4'd7;
      default: funOk = 1'b0;
    endcase
  end
  // illegal instructions leave every strobe low and fall back to alu_op ADD
  always_comb begin
    {regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, branchNot, jump, jumpR, jal, illegal} = '0;
    aluOp = 4'd0;
    case (bus.opcode)
      6'h00:
        if (funOk) begin
          regDst = 1'b1;
          aluOp = 4'd2;
          jumpR = bus.funct == 6'h08;
          regWrite = !jumpR;
        end else illegal = 1'b1;
      6'h23: {aluSrc, memRead, memToReg, regWrite} = '1;
      6'h2B: {aluSrc, memWrite} = '1;
      6'h04: begin branch = 1'b1; aluOp = 4'd1; end
      6'h05: begin branchNot = 1'b1; aluOp = 4'd1; end
      6'h08, 6'h09: {aluSrc, regWrite} = '1;
      6'h0C, 6'h0D, 6'h0E: begin {aluSrc, regWrite} = '1; aluOp = 4'd3 + {2'b0, bus.opcode[1:0]}; end
      6'h0A, 6'h0B: begin {aluSrc, regWrite} = '1; aluOp = 4'd6 + {3'b0, bus.opcode[0]}; end
      6'h0F: begin {aluSrc, regWrite} = '1; aluOp = 4'd8; end
      6'h02: jump = 1'b1;
      6'h03: begin jal = 1'b1; regWrite = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end
  always_comb begin
    case (aluOp)
      4'd1: aluCtl = 4'd8;
      4'd2: aluCtl = funCtl;
      4'd3: aluCtl = 4'd0;
      4'd4: aluCtl = 4'd1;
      4'd5: aluCtl = 4'd3;
      4'd6: aluCtl = 4'd9;
      4'd7: aluCtl = 4'd10;
      4'd8: aluCtl = 4'd11;
      default: aluCtl = 4'd2;
    endcase
  end
  assign immExt = (bus.opcode inside {6'h0C, 6'h0D, 6'h0E}) ? {{(DW-16){1'b0}}, bus.imm16} : {{(DW-16){bus.imm16[15]}}, bus.imm16};
  assign opB = aluSrc ? immExt : bus.rt_data;
  always_comb begin
    case (aluCtl)
      4'd0: res = opA & opB;
      4'd1: res = opA | opB;
      4'd2: res = opA + opB;
      4'd3: res = opA ^ opB;
      4'd4: res = ~(opA | opB);
      4'd5: res = opB << bus.shamt;
      4'd6: res = opB >> bus.shamt;
      4'd7: res = $signed(opB) >>> bus.shamt;
      4'd8: res = opA - opB;
      4'd9: res = {{(DW-1){1'b0}}, $signed(opA) < $signed(opB)};
      4'd10: res = {{(DW-1){1'b0}}, opA < opB};
      4'd11: res = {bus.imm16, {(DW-16){1'b0}}};
      default: res = '0;
    endcase
  end
`ifdef ALU_OVF_EN
  logic addChk, subChk;
  assign addChk = bus.opcode == 6'h08 || (bus.opcode == 6'h00 && bus.funct == 6'h20);
  assign subChk = bus.opcode == 6'h00 && bus.funct == 6'h22;
  assign ovfNext = addChk ? (opA[DW-1] == opB[DW-1] && res[DW-1] != opA[DW-1])
                          : subChk && opA[DW-1] != opB[DW-1] && res[DW-1] != opA[DW-1];
`else
  assign ovfNext = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      {bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write} <= '0;
      {bus.branch, bus.branch_not, bus.jump, bus.jump_r, bus.jal, bus.illegal, bus.ovf} <= '0;
      bus.alu_op <= '0;
      bus.alu_ctl <= '0;
      bus.alu_result <= '0;
      bus.zero <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      {bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write} <= {regDst, aluSrc, memRead, memWrite, memToReg, regWrite};
      {bus.branch, bus.branch_not, bus.jump, bus.jump_r, bus.jal, bus.illegal, bus.ovf} <= {branch, branchNot, jump, jumpR, jal, illegal, ovfNext};
      bus.alu_op <= aluOp;
      bus.alu_ctl <= aluCtl;
      bus.alu_result <= res;
      bus.zero <= res == '0;
    end
  end
endmodule

// File: tb/tb_mips_decode_alu.sv
// tb_mips_decode_alu: directed vectors, reset sequences and random instructions against an instruction-level model
module tb_mips_decode_alu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mips_decode_alu_if bus();
  mips_decode_alu dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic vld;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] sh;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } in_t;
  typedef struct packed {
    logic vld;
    logic [11:0] ctl;
    logic [3:0] aop;
    logic [3:0] actl;
    logic [31:0] res;
    logic zero;
    logic ovf;
  } exp_t;
  typedef struct {
    in_t i;
    logic [11:0] ctl;
    logic [3:0] aop;
    logic [3:0] actl;
    logic [31:0] res;
    logic ovf;
  } vec_t;
  typedef enum int {K_AND, K_OR, K_ADD, K_XOR, K_NOR, K_SLL, K_SRL, K_SRA, K_SUB, K_SLT, K_SLTU, K_LUI} kind_t;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  logic [5:0] opList [15] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h02, 6'h03};
  logic [5:0] fnList [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
  vec_t vecs[$];

  // ctl bit order: reg_dst alu_src mem_read mem_write mem_to_reg reg_write branch branch_not jump jump_r jal illegal
  function automatic exp_t model(input in_t x);
    exp_t e;
    kind_t k;
    logic [31:0] b;
    bit ovChk, isSub;
    longint w;
    e = '0;
    k = K_ADD;
    ovChk = 0;
    isSub = 0;
    case (x.op)
      6'h00: begin
        e.ctl = 12'h840;
        e.aop = 4'd2;
        case (x.fn)
          6'h20: begin k = K_ADD; ovChk = 1; end
          6'h21: k = K_ADD;
          6'h22: begin k = K_SUB; ovChk = 1; isSub = 1; end
          6'h23: k = K_SUB;
          6'h24: k = K_AND;
          6'h25: k = K_OR;
          6'h26: k = K_XOR;
          6'h27: k = K_NOR;
          6'h2A: k = K_SLT;
          6'h2B: k = K_SLTU;
          6'h00: k = K_SLL;
          6'h02: k = K_SRL;
          6'h03: k = K_SRA;
          6'h08: e.ctl = 12'h804;
          default: begin e.ctl = 12'h001; e.aop = 4'd0; end
        endcase
      end
      6'h23: e.ctl = 12'h6C0;
      6'h2B: e.ctl = 12'h500;
      6'h04: begin e.ctl = 12'h020; e.aop = 4'd1; k = K_SUB; end
      6'h05: begin e.ctl = 12'h010; e.aop = 4'd1; k = K_SUB; end
      6'h08: begin e.ctl = 12'h440; ovChk = 1; end
      6'h09: e.ctl = 12'h440;
      6'h0C: begin e.ctl = 12'h440; e.aop = 4'd3; k = K_AND; end
      6'h0D: begin e.ctl = 12'h440; e.aop = 4'd4; k = K_OR; end
      6'h0E: begin e.ctl = 12'h440; e.aop = 4'd5; k = K_XOR; end
      6'h0A: begin e.ctl = 12'h440; e.aop = 4'd6; k = K_SLT; end
      6'h0B: begin e.ctl = 12'h440; e.aop = 4'd7; k = K_SLTU; end
      6'h0F: begin e.ctl = 12'h440; e.aop = 4'd8; k = K_LUI; end
      6'h02: e.ctl = 12'h008;
      6'h03: e.ctl = 12'h042;
      default: e.ctl = 12'h001;
    endcase
    if (!e.ctl[10]) b = x.b;
    else if (x.op inside {6'h0C, 6'h0D, 6'h0E}) b = {16'h0, x.imm};
    else b = {{16{x.imm[15]}}, x.imm};
    case (k)
      K_AND: e.res = x.a & b;
      K_OR: e.res = x.a | b;
      K_ADD: e.res = x.a + b;
      K_XOR: e.res = x.a ^ b;
      K_NOR: e.res = ~(x.a | b);
      K_SLL: e.res = b << x.sh;
      K_SRL: e.res = b >> x.sh;
      K_SRA: e.res = $signed(b) >>> x.sh;
      K_SUB: e.res = x.a - b;
      K_SLT: e.res = ($signed(x.a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU: e.res = (x.a < b) ? 32'd1 : 32'd0;
      default: e.res = {x.imm, 16'h0};
    endcase
    e.actl = 4'(k);
    e.zero = e.res == 32'd0;
    e.vld = x.vld;
    w = isSub ? longint'($signed(x.a)) - longint'($signed(b)) : longint'($signed(x.a)) + longint'($signed(b));
`ifdef ALU_OVF_EN
    e.ovf = ovChk && (w > MAXS || w < MINS);
`else
    e.ovf = 1'b0;
    if (w == 0 && ovChk) e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h", nm, fld, act, want);
    end
  endtask

  task automatic check(input string nm, input exp_t e);
    cmp(nm, "out_valid", 32'(bus.out_valid), 32'(e.vld));
    cmp(nm, "ctl", 32'({bus.reg_dst, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write,
                       bus.branch, bus.branch_not, bus.jump, bus.jump_r, bus.jal, bus.illegal}), 32'(e.ctl));
    cmp(nm, "alu_op", 32'(bus.alu_op), 32'(e.aop));
    cmp(nm, "alu_ctl", 32'(bus.alu_ctl), 32'(e.actl));
    cmp(nm, "alu_result", bus.alu_result, e.res);
    cmp(nm, "zero", 32'(bus.zero), 32'(e.zero));
    cmp(nm, "ovf", 32'(bus.ovf), 32'(e.ovf));
  endtask

  task automatic drive(input in_t x);
    bus.in_valid = x.vld;
    bus.opcode = x.op;
    bus.funct = x.fn;
    bus.shamt = x.sh;
    bus.imm16 = x.imm;
    bus.rs_data = x.a;
    bus.rt_data = x.b;
  endtask

  task automatic addv(input logic [5:0] op, fn, input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] a, b,
                      input logic [11:0] ctl, input logic [3:0] aop, actl, input logic [31:0] res, input logic ovf);
    vec_t v;
    v.i = '{1'b1, op, fn, sh, imm, a, b};
    v.ctl = ctl;
    v.aop = aop;
    v.actl = actl;
    v.res = res;
    v.ovf = ovf;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'($urandom_range(15));
      2: return 32'h7FFFFFFF;
      default: return 32'h80000000;
    endcase
  endfunction

  initial begin
    exp_t e, rstExp;
    in_t x;
    rstExp = '0;
    rstExp.zero = 1'b1;
    addv(6'h00, 6'h20, 0, 16'h0000, 32'd5, 32'd7, 12'h840, 2, 2, 32'd12, 0);
    addv(6'h04, 6'h00, 0, 16'h0003, 32'h1234, 32'h1234, 12'h020, 1, 8, 32'd0, 0);
    addv(6'h05, 6'h00, 0, 16'h0003, 32'd5, 32'd3, 12'h010, 1, 8, 32'd2, 0);
    addv(6'h0D, 6'h00, 0, 16'h8001, 32'hFFFF0000, 32'd9, 12'h440, 4, 1, 32'hFFFF8001, 0);
    addv(6'h08, 6'h00, 0, 16'h8001, 32'hFFFF0000, 32'd9, 12'h440, 0, 2, 32'hFFFE8001, 0);
    addv(6'h00, 6'h03, 4, 16'h0000, 32'h12345678, 32'h80000000, 12'h840, 2, 7, 32'hF8000000, 0);
    addv(6'h00, 6'h2A, 0, 16'h0000, 32'hFFFFFFFF, 32'd1, 12'h840, 2, 9, 32'd1, 0);
    addv(6'h00, 6'h2B, 0, 16'h0000, 32'hFFFFFFFF, 32'd1, 12'h840, 2, 10, 32'd0, 0);
    addv(6'h0F, 6'h00, 0, 16'hABCD, 32'h55, 32'h66, 12'h440, 8, 11, 32'hABCD0000, 0);
    addv(6'h00, 6'h08, 0, 16'h0000, 32'h400, 32'h10, 12'h804, 2, 2, 32'h410, 0);
    addv(6'h03, 6'h00, 0, 16'h0000, 32'd1, 32'd2, 12'h042, 0, 2, 32'd3, 0);
    addv(6'h02, 6'h00, 0, 16'h0000, 32'd1, 32'd2, 12'h008, 0, 2, 32'd3, 0);
    addv(6'h3F, 6'h00, 0, 16'h0000, 32'd1, 32'd2, 12'h001, 0, 2, 32'd3, 0);
    addv(6'h00, 6'h3F, 0, 16'h0000, 32'd1, 32'd2, 12'h001, 0, 2, 32'd3, 0);
    addv(6'h23, 6'h00, 0, 16'hFFFC, 32'h100, 32'd0, 12'h6C0, 0, 2, 32'hFC, 0);
    addv(6'h2B, 6'h00, 0, 16'h0004, 32'h100, 32'd0, 12'h500, 0, 2, 32'h104, 0);
    addv(6'h00, 6'h21, 0, 16'h0000, 32'h7FFFFFFF, 32'd1, 12'h840, 2, 2, 32'h80000000, 0);
    addv(6'h00, 6'h20, 0, 16'h0000, 32'h7FFFFFFF, 32'd1, 12'h840, 2, 2, 32'h80000000, 1);
    addv(6'h00, 6'h22, 0, 16'h0000, 32'h80000000, 32'd1, 12'h840, 2, 8, 32'h7FFFFFFF, 1);
    drive('0);
    #1 rst = 1'b1;
    #1 check("reset", rstExp);
    @(posedge clk);
    #1 rst = 1'b0;
    foreach (vecs[n]) begin
      drive(vecs[n].i);
      @(posedge clk);
      #1;
      e = '0;
      e.vld = 1'b1;
      e.ctl = vecs[n].ctl;
      e.aop = vecs[n].aop;
      e.actl = vecs[n].actl;
      e.res = vecs[n].res;
      e.zero = vecs[n].res == 32'd0;
`ifdef ALU_OVF_EN
      e.ovf = vecs[n].ovf;
`endif
      check($sformatf("vec%0d", n), e);
    end
    x = '{1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7};
    drive(x);
    #2 rst = 1'b1;
    #1 check("rst_mid", rstExp);
    @(posedge clk);
    #1 check("rst_hold", rstExp);
    rst = 1'b0;
    x = '{1'b1, 6'h00, 6'h25, 5'd0, 16'h0, 32'h0F0, 32'h00F};
    drive(x);
    @(posedge clk);
    #1 check("post_rst", '{1'b1, 12'h840, 4'd2, 4'd1, 32'h0FF, 1'b0, 1'b0});
    for (int n = 0; n < 400; n++) begin
      x.vld = 1'($urandom_range(1));
      x.op = ($urandom_range(7) == 0) ? 6'($urandom) : opList[$urandom_range(14)];
      x.fn = ($urandom_range(7) == 0) ? 6'($urandom) : fnList[$urandom_range(13)];
      x.sh = 5'($urandom);
      x.imm = 16'($urandom);
      x.a = pick();
      x.b = pick();
      drive(x);
      @(posedge clk);
      #1 check($sformatf("rnd%0d op=%h fn=%h", n, x.op, x.fn), model(x));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
